// File: rtl/div_bcd_display_pkg.sv
// Shared types and constants for the quotient/remainder BCD display.
package div_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned ITERS  = 5;
  localparam int unsigned DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/div_bcd_display_if.sv
// Request/result bundle between the divider side and the BCD display block.
interface div_bcd_display_if;
  import div_bcd_display_pkg::*;

  logic              start;
  logic [4:0]        quo;
  logic [4:0]        rem;
  logic              busy;
  logic              done;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (output start, quo, rem, input busy, done, seg, an);
  modport slave  (input start, quo, rem, output busy, done, seg, an);
endinterface

// File: rtl/div_bcd_display_bcd_dd5.sv
// One 5-bit double-dabble engine: load a binary value, then step five times.
module bcd_dd5 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [4:0] bin,
  output logic [7:0] bcd
);

  logic [4:0]  bin_r;
  logic [7:0]  bcd_r;
  logic [7:0]  adj;
  logic [12:0] sh;

  always_comb begin
    adj = bcd_r;
    if (bcd_r[3:0] >= 4'd5) adj[3:0] = bcd_r[3:0] + 4'd3;
    if (bcd_r[7:4] >= 4'd5) adj[7:4] = bcd_r[7:4] + 4'd3;
    sh = {adj, bin_r} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_r <= '0;
      bin_r <= '0;
    end else if (load) begin
      bcd_r <= '0;
      bin_r <= bin;
    end else if (step) begin
      bcd_r <= sh[12:5];
      bin_r <= sh[4:0];
    end
  end

  assign bcd = bcd_r;

endmodule

// File: rtl/div_bcd_display.sv
// Converts captured quotient/remainder to BCD and scans them onto a 4-digit
// multiplexed seven-segment display.
module div_bcd_display
  import div_bcd_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input logic              clk,
  input logic              reset,
  div_bcd_display_if.slave bus
);

  state_t                  state, state_n;
  logic [2:0]              iter;
  logic                    load, step, commit;
  logic [7:0]              q_bcd, r_bcd;
  logic [DIGITS-1:0][3:0]  digits, digits_n;
  logic [15:0]             presc, presc_n;
  logic [1:0]              idx, idx_n;
  logic                    done_r;
  logic [6:0]              seg_r;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (iter == 3'(ITERS - 1)) state_n = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || load) iter <= '0;
    else if (step)     iter <= iter + 3'd1;
  end

  bcd_dd5 u_quo (.clk(clk), .reset(reset), .load(load), .step(step), .bin(bus.quo), .bcd(q_bcd));
  bcd_dd5 u_rem (.clk(clk), .reset(reset), .load(load), .step(step), .bin(bus.rem), .bcd(r_bcd));

  always_comb begin
    presc_n  = presc + 16'd1;
    idx_n    = idx;
    if (presc == 16'(SCAN_DIV - 1)) begin
      presc_n = '0;
      idx_n   = idx + 2'd1;
    end
    digits_n = commit ? {q_bcd, r_bcd} : digits;
  end

  // seg is decoded from next-cycle digit and index so it lines up with an
  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      idx    <= '0;
      digits <= '0;
      done_r <= 1'b0;
      seg_r  <= SEG_0;
    end else begin
      presc  <= presc_n;
      idx    <= idx_n;
      digits <= digits_n;
      done_r <= commit;
      seg_r  <= seg_decode(digits_n[idx_n]);
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.seg  = seg_r;
  assign bus.an   = ~(4'b0001 << idx);

endmodule

// File: doc/div_bcd_display.md
DIV_BCD_DISPLAY -- requirements
Module: div_bcd_display

Interface
REQ-001 Parameter SCAN_DIV, default 4, clk cycles each display digit stays enabled before the scan advances; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to convert and display the current quo/rem; sampled only in IDLE.
REQ-005 quo  input  5  unsigned quotient from the upstream divider, 0..31.
REQ-006 rem  input  5  unsigned remainder from the upstream divider, 0..31.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse: new BCD result committed to the display.
REQ-009 seg  output  7  active-low segments {g,f,e,d,c,b,a} for the enabled digit.
REQ-010 an  output  4  active-low digit enables; an[3]=quo tens, an[2]=quo ones, an[1]=rem tens, an[0]=rem ones.

Function
REQ-011 FSM states IDLE, SHIFT, COMMIT; IDLE->SHIFT on start=1 at edge k, capturing quo and rem into working registers at that edge.
REQ-012 SHIFT lasts exactly 5 cycles (edges k+1..k+5), one double-dabble iteration per edge on quo and rem in parallel; a 3-bit iteration counter tracks progress; SHIFT->COMMIT after the 5th iteration.
REQ-013 Each iteration: add 3 to any BCD nibble >=5, then shift {bcd, bin} left by one; each result is 8 bits (tens, ones); tens never exceeds 3.
REQ-014 COMMIT->IDLE at edge k+6; at that edge the four display digit registers load the new BCD values and done is 1 for exactly that following cycle.
REQ-015 busy is 1 in the cycles following edges k..k+5 and 0 otherwise, including the done cycle.
REQ-016 start while busy=1 is ignored and is neither queued nor allowed to corrupt the working registers.
REQ-017 start during the done cycle is accepted, since the FSM is in IDLE, giving back-to-back conversions with a 7-cycle period.
REQ-018 quo/rem changes after the capture edge do not affect the result in progress.
REQ-019 The display digit registers hold their value between commits, and the display is never blanked during a conversion.
REQ-020 The scan prescaler counts 0..SCAN_DIV-1; on wrap the digit index advances 0->1->2->3->0 (wrap-around). The prescaler runs continuously, independent of the FSM.
REQ-021 an is the one-hot-low of the digit index: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
REQ-022 seg decodes the selected digit register with a registered output aligned to an: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 give 1111111.

Reset
REQ-023 reset=1 forces IDLE, busy=0, done=0, working and iteration registers=0, display digits=0, prescaler=0, digit index=0, an=1110, seg=1000000.
REQ-024 reset mid-conversion aborts it: no done pulse, display shows 0000, and the next start is accepted normally.
REQ-025 reset has priority over start and over every other event in the same cycle.

Structure
REQ-026 A shared package holds the FSM state encoding, the iteration count (5), the digit count (4), and the seven-segment code constants.
REQ-027 One sub-module, bcd_dd5, holds one 5-bit double-dabble engine (load, step, 8-bit BCD out) and is instantiated twice: quo and rem.

Verification
REQ-028 Reset, then quo=1, rem=2, start pulse -> done 6 cycles after the capture edge; digits 0,1,0,2; with SCAN_DIV=4, an steps 1110/1101/1011/0111 every 4 cycles and seg=0100100 while an=1110.
REQ-029 quo=31, rem=19 -> digits 3,1,1,9; sweep all 32x32 pairs -> each digit pair equals the decimal value.
REQ-030 start held high for 10 cycles with quo changing each cycle -> exactly one conversion starts, using the first-captured value; a second start is accepted on the done cycle.
REQ-031 reset asserted in the 3rd SHIFT cycle -> busy=0 next cycle, no done, an=1110, seg=1000000.
REQ-032 SCAN_DIV=1 -> the digit index advances every cycle; a commit mid-scan updates seg on the next cycle without disturbing the an sequence.
